// File: rtl/lsu_pkg.sv
// Shared definitions for the multicycle load/store unit: FSM state codes, fault codes,
// default memory map and the byte-enable helper.
package lsu_pkg;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t IDLE  = 2'd0;
    localparam lsu_state_t REQ   = 2'd1;
    localparam lsu_state_t DONE  = 2'd2;
    localparam lsu_state_t FAULT = 2'd3;

    typedef logic [1:0] lsu_fault_t;

    localparam lsu_fault_t FC_NONE     = 2'b00;
    localparam lsu_fault_t FC_WPROT    = 2'b01;
    localparam lsu_fault_t FC_MISALIGN = 2'b10;
    localparam lsu_fault_t FC_TIMEOUT  = 2'b11;

    localparam logic [15:0] MAP_INSTRUCTION_MEM   = 16'h0000;
    localparam logic [15:0] MAP_INTERRUPT_CONTROL = 16'h5FFF;
    localparam logic [15:0] MAP_DATA_STACK        = 16'h6FFE;
    localparam logic [15:0] MAP_IO_MEM            = 16'hCFFD;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 32'd15;

    // Little-endian lane enables: [1] is the upper lane.
    function automatic logic [1:0] lane_enables(input logic byte_mode, input logic addr_lsb);
        logic [1:0] be;
        if (byte_mode) begin
            be = {addr_lsb, ~addr_lsb};
        end else begin
            be = 2'b11;
        end
        return be;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering: store-data replication and byte enables on the way out,
// lane selection plus sign/zero extension on the way back in.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_st_byte,
    input  logic             i_st_addr_lsb,
    input  logic [WIDTH-1:0] i_st_wdata,
    input  logic             i_ld_byte,
    input  logic             i_ld_sext,
    input  logic             i_ld_addr_lsb,
    input  logic [WIDTH-1:0] i_ld_rdata,
    output logic [WIDTH-1:0] o_st_data,
    output logic [1:0]       o_st_be,
    output logic [WIDTH-1:0] o_ld_data
);
    localparam int unsigned HALF = WIDTH / 32'd2;

    logic [HALF-1:0] w_lane;
    logic            w_fill;

    assign w_lane = i_ld_addr_lsb ? i_ld_rdata[WIDTH-1:HALF] : i_ld_rdata[HALF-1:0];
    assign w_fill = i_ld_sext & w_lane[HALF-1];

    // Load extraction and store replication.
    always_comb begin
        o_st_be = lane_enables(i_st_byte, i_st_addr_lsb);
        if (i_st_byte) begin
            o_st_data = {2{i_st_wdata[HALF-1:0]}};
        end else begin
            o_st_data = i_st_wdata;
        end
        if (i_ld_byte) begin
            o_ld_data = {{HALF{w_fill}}, w_lane};
        end else begin
            o_ld_data = i_ld_rdata;
        end
    end

endmodule

// File: rtl/lsu_multicycle.sv
// Multicycle load/store unit: one command at a time over a request/ready memory port,
// with misalignment, write-protect and timeout faults and I/O-region flagging.
module lsu_multicycle
    import lsu_pkg::*;
#(
    parameter int unsigned      WIDTH             = 32'd16,
    parameter logic [WIDTH-1:0] INSTRUCTION_MEM   = WIDTH'(MAP_INSTRUCTION_MEM),
    parameter logic [WIDTH-1:0] INTERRUPT_CONTROL = WIDTH'(MAP_INTERRUPT_CONTROL),
    parameter logic [WIDTH-1:0] DATA_STACK        = WIDTH'(MAP_DATA_STACK),
    parameter logic [WIDTH-1:0] IO_MEM            = WIDTH'(MAP_IO_MEM),
    parameter int unsigned      TIMEOUT           = LSU_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_store,
    input  logic             byte_mode,
    input  logic             sign_ext,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic             io_access,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [1:0]       mem_be,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam int unsigned CW = $clog2(TIMEOUT + 32'd1);

    if ((WIDTH < 32'd16) || ((WIDTH % 32'd2) != 32'd0) || (TIMEOUT < 32'd1) || (TIMEOUT > 32'd255) ||
        (INTERRUPT_CONTROL < INSTRUCTION_MEM) || (DATA_STACK < INTERRUPT_CONTROL) ||
        (IO_MEM < DATA_STACK)) begin : g_bad_params
        $error("lsu_multicycle: illegal parameter set");
    end

    lsu_state_t     r_state, w_state_nxt;
    logic           r_pend, w_pend_nxt;
    lsu_fault_t     r_code, w_code_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_inc;
    logic           r_is_store, r_byte, r_sext, r_addr_lsb, r_io;
    logic           w_accept, w_misalign, w_wprot, w_io, w_timeout, w_done_nxt;
    logic [WIDTH-1:0] w_st_data, w_ld_data;
    logic [1:0]     w_st_be;

    assign w_accept   = (r_state == IDLE) & start;
    assign w_misalign = ~byte_mode & addr[0];
    assign w_wprot    = is_store & (addr < INTERRUPT_CONTROL);
    assign w_io       = (addr >= IO_MEM);
    assign w_cnt_inc  = r_cnt + CW'(32'd1);
    assign w_timeout  = (w_cnt_inc == CW'(TIMEOUT));
    // An IDLE-detected fault spends one pending cycle in FAULT so its done lands at cycle 2.
    assign w_done_nxt = (w_state_nxt == DONE) | ((w_state_nxt == FAULT) & ~w_pend_nxt);

    lsu_byte_lane #(.WIDTH(WIDTH)) u_lane (
        .i_st_byte     (byte_mode),
        .i_st_addr_lsb (addr[0]),
        .i_st_wdata    (wdata),
        .i_ld_byte     (r_byte),
        .i_ld_sext     (r_sext),
        .i_ld_addr_lsb (r_addr_lsb),
        .i_ld_rdata    (mem_rdata),
        .o_st_data     (w_st_data),
        .o_st_be       (w_st_be),
        .o_ld_data     (w_ld_data)
    );

    // Next-state, pending flag and fault-code selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = 1'b0;
        w_code_nxt  = r_code;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_misalign) begin
                        w_state_nxt = FAULT;
                        w_pend_nxt  = 1'b1;
                        w_code_nxt  = FC_MISALIGN;
                    end else if (w_wprot) begin
                        w_state_nxt = FAULT;
                        w_pend_nxt  = 1'b1;
                        w_code_nxt  = FC_WPROT;
                    end else begin
                        w_state_nxt = REQ;
                        w_code_nxt  = FC_NONE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    w_state_nxt = DONE;
                end else if (w_timeout) begin
                    w_state_nxt = FAULT;
                    w_code_nxt  = FC_TIMEOUT;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            FAULT: begin
                if (r_pend) begin
                    w_state_nxt = FAULT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, fault code and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_code  <= FC_NONE;
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_code  <= w_code_nxt;
            if (w_accept) begin
                r_cnt <= {CW{1'b0}};
            end else if ((r_state == REQ) && (w_state_nxt == REQ)) begin
                r_cnt <= w_cnt_inc;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Command latch, taken only when a command is accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_store <= 1'b0;
            r_byte     <= 1'b0;
            r_sext     <= 1'b0;
            r_addr_lsb <= 1'b0;
            r_io       <= 1'b0;
        end else if (w_accept) begin
            r_is_store <= is_store;
            r_byte     <= byte_mode;
            r_sext     <= sign_ext;
            r_addr_lsb <= addr[0];
            r_io       <= w_io;
        end
    end

    // Status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            io_access  <= 1'b0;
        end else begin
            busy       <= (w_state_nxt != IDLE);
            done       <= w_done_nxt;
            fault      <= w_done_nxt & (w_state_nxt == FAULT);
            fault_code <= (w_done_nxt & (w_state_nxt == FAULT)) ? w_code_nxt : FC_NONE;
            io_access  <= w_done_nxt & r_io;
        end
    end

    // Memory request bus, loaded on entry to REQ and held stable through it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {WIDTH{1'b0}};
            mem_wdata <= {WIDTH{1'b0}};
            mem_be    <= 2'b00;
        end else if (w_accept && (w_state_nxt == REQ)) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[WIDTH-1:1], 1'b0};
            mem_wdata <= w_st_data;
            mem_be    <= w_st_be;
        end else if (w_state_nxt != REQ) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {WIDTH{1'b0}};
            mem_wdata <= {WIDTH{1'b0}};
            mem_be    <= 2'b00;
        end
    end

    // Load result, held until the next load completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= {WIDTH{1'b0}};
        end else if ((r_state == REQ) && mem_ready && !r_is_store) begin
            rdata <= w_ld_data;
        end
    end

endmodule

// File: tb/tb_lsu_multicycle.sv
// Self-checking bench for lsu_multicycle: directed scenarios followed by randomized
// commands, each compared against an arithmetic reference of the command's outcome.
module tb_lsu_multicycle;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_store, byte_mode, sign_ext;
    logic [15:0] addr, wdata;
    logic        busy, done, fault, io_access;
    logic [1:0]  fault_code;
    logic [15:0] rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] model_rdata = 16'h0000;

    always #5 clk = ~clk;

    lsu_multicycle #(.WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .byte_mode(byte_mode), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .fault_code(fault_code),
        .io_access(io_access), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_code(input logic st, input logic byt, input int a, input int waits);
        if (!byt && (a % 2 == 1)) return 2;
        if (st && (a < 'h5FFF)) return 1;
        if (waits >= TO) return 3;
        return 0;
    endfunction

    function automatic int ref_load(input logic byt, input logic sx, input int a, input int m);
        int lane;
        if (!byt) return m;
        lane = (a % 2 == 1) ? (m / 256) : (m % 256);
        if (sx && lane >= 128) return lane + 'hFF00;
        return lane;
    endfunction

    task automatic run_cmd(input string tag, input logic st, input logic byt, input logic sx,
                           input logic [15:0] a, input logic [15:0] wd, input logic [15:0] md,
                           input int waits, input logic poke);
        int code, edone, ereq, nreq, cyc, ebe, ewd, erd;
        logic got_done;
        code = ref_code(st, byt, int'(a), waits);
        if (code == 1 || code == 2) begin edone = 2; ereq = 0; end
        else if (code == 3) begin edone = TO + 1; ereq = TO; end
        else begin edone = waits + 2; ereq = waits + 1; end
        erd = int'(model_rdata);
        if (code == 0 && !st) erd = ref_load(byt, sx, int'(a), int'(md));
        ebe = !byt ? 3 : ((a % 2 == 1) ? 2 : 1);
        ewd = byt ? (int'(wd) % 256) * 257 : int'(wd);

        @(negedge clk);
        start = 1'b1; is_store = st; byte_mode = byt; sign_ext = sx;
        addr = a; wdata = wd; mem_rdata = md; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (poke) begin
            addr = 16'($urandom); wdata = 16'($urandom); is_store = ~st; byte_mode = ~byt;
        end else begin
            start = 1'b0;
        end
        nreq = 0; cyc = 1; got_done = 1'b0;
        while (!got_done && cyc <= TO + 5) begin
            if (mem_req) begin
                nreq++;
                chk({tag, ".mem_addr"}, mem_addr, a & 16'hFFFE);
                chk({tag, ".mem_be"}, mem_be, ebe);
                chk({tag, ".mem_we"}, mem_we, st);
                if (st) chk({tag, ".mem_wdata"}, mem_wdata, ewd);
                mem_ready = (nreq > waits);
            end else begin
                mem_ready = 1'($urandom);
            end
            if (done) begin
                got_done = 1'b1;
                chk({tag, ".done_cycle"}, cyc, edone);
                chk({tag, ".req_cycles"}, nreq, ereq);
                chk({tag, ".fault"}, fault, (code != 0));
                chk({tag, ".fault_code"}, fault_code, code);
                chk({tag, ".io_access"}, io_access, (int'(a) >= 'hCFFD));
                chk({tag, ".rdata"}, rdata, erd);
                chk({tag, ".busy_at_done"}, busy, 1);
            end else begin
                chk({tag, ".busy"}, busy, 1);
                cyc++;
                @(negedge clk);
            end
        end
        if (!got_done) chk({tag, ".done_seen"}, 0, 1);
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0;
        chk({tag, ".idle_busy"}, busy, 0);
        chk({tag, ".idle_done"}, done, 0);
        @(negedge clk);
        chk({tag, ".single_done"}, done, 0);
        chk({tag, ".idle_req"}, mem_req, 0);
        model_rdata = 16'(erd);
    endtask

    initial begin
        logic [15:0] ra;
        reset = 1'b0; start = 1'b0; is_store = 1'b0; byte_mode = 1'b0; sign_ext = 1'b0;
        addr = 16'h0000; wdata = 16'h0000; mem_ready = 1'b0; mem_rdata = 16'h0000;
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.fault", {fault, fault_code}, 0);
        chk("rst.mem_req", {mem_req, mem_we, mem_be}, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.mem_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;

        run_cmd("wload",     1'b0, 1'b0, 1'b0, 16'h7000, 16'h0000, 16'hBEEF, 0, 1'b0);
        run_cmd("bload_sx",  1'b0, 1'b1, 1'b1, 16'h7001, 16'h0000, 16'h80FF, 3, 1'b0);
        run_cmd("bload_zx",  1'b0, 1'b1, 1'b0, 16'h7001, 16'h0000, 16'h80FF, 3, 1'b0);
        run_cmd("bstore",    1'b1, 1'b1, 1'b0, 16'h7002, 16'h12AB, 16'h0000, 0, 1'b0);
        run_cmd("wprot",     1'b1, 1'b0, 1'b0, 16'h1000, 16'h5555, 16'h0000, 0, 1'b0);
        run_cmd("misalign",  1'b0, 1'b0, 1'b0, 16'h7003, 16'h0000, 16'h1234, 0, 1'b0);
        run_cmd("timeout",   1'b0, 1'b0, 1'b0, 16'hD000, 16'h0000, 16'h1234, 40, 1'b0);
        run_cmd("edge_wait", 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h4321, TO - 1, 1'b0);
        run_cmd("busy_poke", 1'b1, 1'b0, 1'b0, 16'hE000, 16'hCAFE, 16'h0000, 2, 1'b1);

        // Reset in the middle of a request aborts the transfer.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; byte_mode = 1'b0; addr = 16'h7000; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort.req_before", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("abort.mem_req", mem_req, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.rdata", rdata, 0);
        model_rdata = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.no_done", done, 0);
        run_cmd("after_rst", 1'b0, 1'b1, 1'b1, 16'h9000, 16'h0000, 16'h00F0, 1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(16'h6000 + $urandom_range(0, 16'h9FFF));
            run_cmd("rand", 1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom),
                    16'($urandom), $urandom_range(0, TO + 2), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
